// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and default parameters for the serial sequence
//               detector family.
//               - seq_state_t : detector FSM state (FILLING / ARMED)
//               - DEF_*       : default length, pattern, overlap mode and
//                               counter width
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } seq_state_t;

  localparam int                 DEF_LEN     = 4;
  localparam logic [DEF_LEN-1:0] DEF_PATTERN = 4'b1011;
  localparam bit                 DEF_OVERLAP = 1'b1;
  localparam int                 DEF_CNT_W   = 8;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones instead of wrapping.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset (count -> 0)
//               i_inc   - increment request
//               i_clr   - synchronous clear, wins over i_inc
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector_param
// Description : Parametrised serial sequence detector. Raises a one-cycle
//               registered pulse whenever the last LEN accepted bits equal
//               the current pattern. Pattern is reloadable at run time;
//               overlapping or non-overlapping matching is selected by
//               OVERLAP. Matches are counted by a saturating counter.
// Ports       : clk           - clock, rising edge
//               rst           - synchronous active-high reset
//               i_en          - accept i_bit this cycle
//               i_bit         - serial data bit
//               i_pat_load    - load i_pat_in as the new pattern
//               i_pat_in      - new pattern, MSB is the oldest bit
//               o_out         - registered match pulse
//               o_armed       - next accepted bit can complete a match
//               o_match_count - saturating match count since reset/load
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
  parameter bit             OVERLAP = DEF_OVERLAP,
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_bit,
  input  logic             i_pat_load,
  input  logic [LEN-1:0]   i_pat_in,
  output logic             o_out,
  output logic             o_armed,
  output logic [CNT_W-1:0] o_match_count
);

  localparam int                FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(LEN - 1);

  // Only the newest LEN-1 bits are kept: the oldest bit of a window is
  // never needed again once the candidate has been formed.
  logic [LEN-2:0]    r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [LEN-1:0]    r_pat;
  seq_state_t        r_state;
  logic              r_out;

  logic [LEN-1:0]    w_cand;
  logic              w_match;
  logic              w_hit;
  logic [FILL_W-1:0] w_fill_inc;

  always_comb begin
    w_cand     = {r_hist, i_bit};
    // The fill gate keeps stale history (after reset, load or a
    // non-overlapping match) from producing a match.
    w_match    = (w_cand == r_pat) && (r_fill >= FILL_ARM);
    w_hit      = i_en && !i_pat_load && w_match;
    w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= PATTERN;
      r_state <= FILLING;
      r_out   <= 1'b0;
    end else if (i_pat_load) begin
      r_pat   <= i_pat_in;
      r_fill  <= '0;
      r_state <= FILLING;
      r_out   <= 1'b0;
    end else if (i_en) begin
      r_hist <= w_cand[LEN-2:0];
      if (w_match) begin
        r_out <= 1'b1;
        if (OVERLAP) begin
          r_fill  <= FILL_FULL;
          r_state <= ARMED;
        end else begin
          r_fill  <= '0;
          r_state <= FILLING;
        end
      end else begin
        r_out  <= 1'b0;
        r_fill <= w_fill_inc;
        if (w_fill_inc >= FILL_ARM) begin
          r_state <= ARMED;
        end
      end
    end else begin
      r_out <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit),
    .i_clr   (i_pat_load),
    .o_count (o_match_count)
  );

  assign o_out   = r_out;
  assign o_armed = (r_state == ARMED);

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector_param
// Description : Self-checking bench for seq_detector_param. Three instances
//               share one stimulus stream: overlapping (CNT_W=8),
//               non-overlapping (CNT_W=8) and overlapping with a 2-bit
//               counter. A window-based model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector_param;

  localparam int L = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         din;
  logic         pat_load;
  logic [L-1:0] pat_in;

  logic       out_ov, armed_ov;
  logic [7:0] cnt_ov;
  logic       out_no, armed_no;
  logic [7:0] cnt_no;
  logic       out_sat, armed_sat;
  logic [1:0] cnt_sat;

  int n_checks = 0;
  int n_errors = 0;

  seq_detector_param #(.LEN(L), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .i_en(en), .i_bit(din), .i_pat_load(pat_load),
    .i_pat_in(pat_in), .o_out(out_ov), .o_armed(armed_ov), .o_match_count(cnt_ov));

  seq_detector_param #(.LEN(L), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .i_en(en), .i_bit(din), .i_pat_load(pat_load),
    .i_pat_in(pat_in), .o_out(out_no), .o_armed(armed_no), .o_match_count(cnt_no));

  seq_detector_param #(.LEN(L), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .i_en(en), .i_bit(din), .i_pat_load(pat_load),
    .i_pat_in(pat_in), .o_out(out_sat), .o_armed(armed_sat), .o_match_count(cnt_sat));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance, the number of bits accepted in the current window
  // and the recent bits as an integer. A match needs a full window whose
  // last L bits equal the pattern.
  bit          ovl  [3] = '{1'b1, 1'b0, 1'b1};
  int          cmax [3] = '{255, 255, 3};
  int          m_len [3];
  logic [31:0] m_hist[3];
  logic [L-1:0] m_pat[3];
  int          m_cnt [3];
  int          m_out [3];
  int          m_arm [3];

  task automatic check(input string name, input int k, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s[%0d] t=%0t: got %0d, expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_len[k] = 0; m_hist[k] = '0; m_pat[k] = 4'b1011;
        m_cnt[k] = 0; m_out[k] = 0;
      end else if (pat_load) begin
        m_pat[k] = pat_in; m_len[k] = 0; m_cnt[k] = 0; m_out[k] = 0;
      end else if (en) begin
        m_hist[k] = {m_hist[k][30:0], din};
        m_len[k]  = m_len[k] + 1;
        if ((m_len[k] >= L) && (m_hist[k][L-1:0] == m_pat[k])) begin
          m_out[k] = 1;
          if (m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
          if (!ovl[k]) m_len[k] = 0;
        end else begin
          m_out[k] = 0;
        end
      end else begin
        m_out[k] = 0;
      end
      m_arm[k] = (m_len[k] >= L - 1) ? 1 : 0;
    end
  endtask

  task automatic compare();
    check("out",   0, out_ov,    m_out[0]);
    check("armed", 0, armed_ov,  m_arm[0]);
    check("count", 0, cnt_ov,    m_cnt[0]);
    check("out",   1, out_no,    m_out[1]);
    check("armed", 1, armed_no,  m_arm[1]);
    check("count", 1, cnt_no,    m_cnt[1]);
    check("out",   2, out_sat,   m_out[2]);
    check("armed", 2, armed_sat, m_arm[2]);
    check("count", 2, cnt_sat,   m_cnt[2]);
  endtask

  // Drive inputs on the falling edge, let the DUT take them on the rising
  // edge, then compare shortly after.
  task automatic step(input logic r, input logic ld, input logic [L-1:0] pin,
                      input logic e, input logic b);
    rst = r; pat_load = ld; pat_in = pin; en = e; din = b;
    @(posedge clk);
    model_update();
    #1;
    compare();
    @(negedge clk);
  endtask

  logic s7[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; en = 1'b0; din = 1'b0; pat_load = 1'b0; pat_in = '0;
    @(negedge clk);

    // Reset then idle
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("lit_rst_out",   0, out_ov,   0);
    check("lit_rst_armed", 0, armed_ov, 0);
    check("lit_rst_count", 0, cnt_ov,   0);
    repeat (10) step(0, 0, 0, 0, 1'($urandom_range(0, 1)));
    check("lit_idle_armed", 1, armed_no, 0);
    check("lit_idle_count", 1, cnt_no,   0);

    // 1,0,1,1,0,1,1 against 1011
    for (int j = 0; j < 7; j++) begin
      step(0, 0, 0, 1, s7[j]);
      if (j == 1) check("lit_armed_b2", 0, armed_ov, 0);
      if (j == 2) check("lit_armed_b3", 0, armed_ov, 1);
      if (j == 3) begin
        check("lit_out_b4",    0, out_ov,   1);
        check("lit_out_b4",    1, out_no,   1);
        check("lit_armed_b4",  1, armed_no, 0);
      end
      if (j == 4) check("lit_out_b5", 0, out_ov, 0);
      if (j == 6) begin
        check("lit_out_b7",   0, out_ov, 1);
        check("lit_out_b7",   1, out_no, 0);
        check("lit_count_b7", 0, cnt_ov, 2);
        check("lit_count_b7", 1, cnt_no, 1);
      end
    end

    // Load 1111 (accompanying bit dropped), then eight 1s
    step(0, 1, 4'b1111, 1, 1);
    check("lit_load_clr", 0, cnt_ov, 0);
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 1, 1);
      if (j == 4) check("lit_1111_b5", 1, out_no, 0);
      if (j == 7) begin
        check("lit_1111_out8", 1, out_no,  1);
        check("lit_1111_cnt",  1, cnt_no,  2);
        check("lit_1111_cnt",  0, cnt_ov,  5);
        check("lit_sat_cnt",   2, cnt_sat, 3);
      end
    end

    // en gaps: 1,0,[gap x3],1,1
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    check("lit_gap_pre", 0, out_ov, 0);
    step(0, 0, 0, 1, 1);
    check("lit_gap_out", 0, out_ov, 1);
    check("lit_gap_cnt", 0, cnt_ov, 1);
    step(0, 0, 0, 0, 0);
    check("lit_gap_pulse1", 0, out_ov, 0);

    // Mid-stream load of 0110
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("lit_pre_load_cnt", 0, cnt_ov, 2);
    step(0, 1, 4'b0110, 1, 0);
    check("lit_load_cnt", 0, cnt_ov, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("lit_0110_pre", 0, out_ov, 0);
    step(0, 0, 0, 1, 0);
    check("lit_0110_out", 0, out_ov, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    check("lit_old_pat", 0, cnt_ov, 1);

    // Reset on the cycle of a completing bit
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check("lit_rst_hit_out", 0, out_ov, 0);
    check("lit_rst_hit_cnt", 0, cnt_ov, 0);

    // Randomised stream
    for (int n = 0; n < 3000; n++) begin
      logic         r, ld, e, b;
      logic [L-1:0] p;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 59) == 0);
      e  = ($urandom_range(0, 9) < 7);
      b  = 1'($urandom_range(0, 1));
      p  = 4'($urandom_range(0, 15));
      step(r, ld, p, e, b);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_detector_param
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector. It watches a 1-bit input stream and raises a one-cycle flag each time the last LEN accepted bits equal a pattern. The pattern has a compile-time default and can be reloaded at run time. Overlapping and non-overlapping match modes are selectable, and a saturating match counter is maintained. It replaces the fixed 5-state hand-coded detectors in the sequence-detector family as the generic building block for serial-pattern recognition.

## Interface
- LEN, 4, pattern length in bits; legal range 2..32
- PATTERN, 4'b1011, reset pattern, LEN bits; MSB is the oldest bit
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match
- CNT_W, 8, width of the match counter
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- en  input  1  when high, `i` is accepted this cycle
- i  input  1  serial data bit
- pat_load  input  1  load `pat_in` as the new pattern
- pat_in  input  LEN  new pattern, MSB oldest
- out  output  1  registered match pulse
- armed  output  1  high when at least LEN-1 bits are held, i.e. the next accepted bit can complete a match
- match_count  output  CNT_W  saturating count of matches since reset or last pattern load

## Operation
- Internal state:
  - hist[LEN-1:0], shift register of accepted bits
  - fill, range 0..LEN, width $clog2(LEN+1)
  - pat[LEN-1:0]
  - 2-state FSM {FILLING, ARMED}
- Reset values: hist=0, fill=0, pat=PATTERN, FSM=FILLING, out=0, armed=0, match_count=0.
- Priority each cycle: reset > pat_load > en.
- pat_load=1:
  - pat<=pat_in, fill<=0, FSM<=FILLING, out<=0, match_count<=0.
  - The bit on `i` is discarded even if en=1.
- en=1 (no reset, no load):
  - hist<={hist[LEN-2:0], i}.
  - cand={hist[LEN-2:0], i}.
  - match = (cand==pat) && (fill>=LEN-1).
- On match:
  - out<=1.
  - match_count increments, holding at all-ones.
  - OVERLAP=1: fill<=LEN and FSM stays ARMED.
  - OVERLAP=0: fill<=0 and FSM<=FILLING. Stale hist bits cannot contribute because fill gates matching.
- On en=1 without match: out<=0, fill<=min(fill+1, LEN).
- FSM transitions:
  - FILLING→ARMED when fill becomes ≥LEN-1.
  - ARMED→FILLING only on pat_load, reset, or a non-overlap match.
- armed is registered and equals (FSM==ARMED).
- en=0: all state holds; out<=0.

## Timing
- Bit accepted at edge k → out high in the cycle after edge k, for exactly one cycle. Latency is 1.
- Back-to-back matches (OVERLAP=1, periodic pattern) give out high on consecutive cycles.
- match_count updates on the same edge as out.
- pat_load at edge k: first bit that can be matched against the new pattern is the LEN-th accepted bit after edge k.
- Reset asserted mid-stream clears everything at that edge. The first accepted bit after deassertion is bit 1 of a new window.

## Structure
- Package seq_det_pkg:
  - typedef enum logic {FILLING, ARMED} seq_state_t
  - localparam defaults for LEN, PATTERN, CNT_W
- One sub-module, sat_counter (parameter W; ports inc, clr, count).
  - Used for match_count.
  - Reused by other detectors in this family.

## Test plan
- Reset then idle: after reset, out=0, armed=0, match_count=0. en=0 for 10 cycles → all outputs unchanged.
- OVERLAP=1, PATTERN=1011, stream 1,0,1,1,0,1,1 with en=1 → out pulses after bits 4 and 7; match_count=2. armed rises after bit 3.
- OVERLAP=0, same stream → out pulses after bit 4 only; match_count=1. Pattern 1111 with stream of eight 1s → pulses after bits 4 and 8.
- en gaps: stream 1,0,[en=0 ×3],1,1 → single pulse one cycle after the final bit. Bits presented while en=0 are ignored.
- pat_load: pat_in=0110 loaded mid-stream alongside en=1 → count clears, that bit is dropped. Then stream 0,1,1,0 → one pulse; the old pattern 1011 no longer matches.
- Saturation and reset: CNT_W=2, five matches → match_count stays 3. Reset asserted on the same cycle as a completing bit → out=0, count=0, no pulse.
